// File: rtl/watchdog_ctrl.sv
// Register-mapped controller for the watchdog timer: CTRL/KICK/STATUS/ID.
// Optional CTRL write lock enabled by defining WDT_CTRL_LOCK_EN.
module watchdog_ctrl #(
  parameter int unsigned RST_STRETCH = 16,
  parameter logic [7:0]  KEY1        = 8'h55,
  parameter logic [7:0]  KEY2        = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       pc_rst,
  output logic       EN,
  output logic       prescale_0,
  output logic       prescale_1,
  output logic       prescale_2,
  output logic       watchdog_rst,
  output logic       cpu_rst
);

  localparam logic K_IDLE  = 1'b0;
  localparam logic K_ARMED = 1'b1;
  localparam logic [7:0] ID_VAL = 8'hA5;
  localparam logic [7:0] STRETCH_LD = 8'(RST_STRETCH);

  logic       en_q, en_d;
  logic [2:0] presc_q, presc_d;
  logic       fired_q, fired_d;
  logic       kerr_q, kerr_d;
  logic       kst_q, kst_d;
  logic [7:0] stretch_q, stretch_d;
  logic       wdrst_q, wdrst_d;
  logic       sync1_q, sync2_q, prev_q, fire_q;
  logic       lock_rd;

  logic ctrl_wr, kick_wr, sts_wr;
  logic kick_ok, kerr_set;

`ifdef WDT_CTRL_LOCK_EN
  logic lock_q, lock_d;
  assign ctrl_wr = wr_en && addr == 2'd0 && !lock_q;
  assign lock_d  = lock_q | (ctrl_wr & wdata[7]);
  assign lock_rd = lock_q;
`else
  assign ctrl_wr = wr_en && addr == 2'd0;
  assign lock_rd = 1'b0;
`endif

  // A pending fire masks the kick so the fire alone decides the FSM
  assign kick_wr = wr_en && addr == 2'd1 && !fire_q;
  assign sts_wr  = wr_en && addr == 2'd2;

  always_comb begin
    kst_d    = kst_q;
    kick_ok  = 1'b0;
    kerr_set = 1'b0;
    if (fire_q) begin
      kst_d = K_IDLE;
    end else if (kick_wr) begin
      if (kst_q == K_IDLE) begin
        if (wdata == KEY1) kst_d = K_ARMED;
        else kerr_set = 1'b1;
      end else begin
        kst_d = K_IDLE;
        if (wdata == KEY2) kick_ok = 1'b1;
        else kerr_set = 1'b1;
      end
    end
  end

  always_comb begin
    en_d    = en_q;
    presc_d = presc_q;
    if (ctrl_wr) begin
      en_d    = wdata[0];
      presc_d = wdata[3:1];
    end
    fired_d = fire_q | (fired_q & ~(sts_wr & wdata[0]));
    kerr_d  = kerr_set | (kerr_q & ~(sts_wr & wdata[1]));
    if (fire_q) stretch_d = STRETCH_LD;
    else if (stretch_q != 8'd0) stretch_d = stretch_q - 8'd1;
    else stretch_d = 8'd0;
    wdrst_d = ctrl_wr | kick_ok | fire_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      presc_q   <= 3'b000;
      fired_q   <= 1'b0;
      kerr_q    <= 1'b0;
      kst_q     <= K_IDLE;
      stretch_q <= 8'd0;
      wdrst_q   <= 1'b1;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      fire_q    <= 1'b0;
`ifdef WDT_CTRL_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      en_q      <= en_d;
      presc_q   <= presc_d;
      fired_q   <= fired_d;
      kerr_q    <= kerr_d;
      kst_q     <= kst_d;
      stretch_q <= stretch_d;
      wdrst_q   <= wdrst_d;
      sync1_q   <= pc_rst;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      fire_q    <= sync2_q & ~prev_q;
`ifdef WDT_CTRL_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      2'd0: rdata = {lock_rd, 3'b000, presc_q, en_q};
      2'd1: rdata = 8'h00;
      2'd2: rdata = {4'b0000, kst_q, cpu_rst, kerr_q, fired_q};
      default: rdata = ID_VAL;
    endcase
  end

  assign cpu_rst      = stretch_q != 8'd0;
  assign EN           = en_q;
  assign prescale_0   = presc_q[0];
  assign prescale_1   = presc_q[1];
  assign prescale_2   = presc_q[2];
  assign watchdog_rst = wdrst_q;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Scoreboard bench for watchdog_ctrl: driver queues expectations,
// a negedge monitor pops and compares them.
module tb_watchdog_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       pc_rst = 1'b0;
  logic       EN, prescale_0, prescale_1, prescale_2;
  logic       watchdog_rst, cpu_rst;

  watchdog_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .pc_rst(pc_rst),
    .EN(EN), .prescale_0(prescale_0), .prescale_1(prescale_1),
    .prescale_2(prescale_2), .watchdog_rst(watchdog_rst),
    .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  // kind: 0 rdata, 1 output vector, 2 wdrst cycles, 3 cpu_rst cycles, 4 clear
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic probe = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wd_cnt = 0;
  int   cr_cnt = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (watchdog_rst === 1'b1) wd_cnt++;
    if (cpu_rst === 1'b1) cr_cnt++;
    if (probe) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: probe with no expectation");
      end else begin
        e = sb.pop_front();
        act = '0;
        case (e.kind)
          0: act = {24'd0, rdata};
          1: act = {26'd0, EN, prescale_2, prescale_1, prescale_0,
                    watchdog_rst, cpu_rst};
          2: begin act = wd_cnt; wd_cnt = 0; end
          3: begin act = cr_cnt; cr_cnt = 0; end
          default: begin wd_cnt = 0; cr_cnt = 0; end
        endcase
        if (e.kind != 4) begin
          checks++;
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp,
                     input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp,
                    input string name);
    addr = a;
    chk(0, {24'd0, exp}, name);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  initial begin
    // reset: vector is {EN,p2,p1,p0,watchdog_rst,cpu_rst}
    idle(1);
    chk(1, 32'b000010, "rst_outs_a");
    chk(1, 32'b000010, "rst_outs_b");
    rst = 1'b0;
    chk(4, 0, "clr");
    rd(2'd3, 8'hA5, "id_read");
    rd(2'd2, 8'h00, "status_rst");
    rd(2'd0, 8'h00, "ctrl_rst");
    chk(1, 32'b000000, "outs_after_rst");
    chk(2, 0, "no_wdrst_idle");

    // CTRL write
    wr(2'd0, 8'h0B);
    chk(1, 32'b110110, "ctrl_wr_outs");
    idle(2);
    chk(2, 1, "ctrl_wdrst_len");
    rd(2'd0, 8'h0B, "ctrl_readback");

    // good kick
    wr(2'd1, 8'h55);
    rd(2'd2, 8'h08, "armed_status");
    wr(2'd1, 8'hAA);
    idle(2);
    chk(2, 1, "kick_pulse");
    rd(2'd2, 8'h00, "kick_status");

    // bad kicks
    wr(2'd1, 8'h55);
    wr(2'd1, 8'h12);
    idle(1);
    chk(2, 0, "badkick_nopulse");
    rd(2'd2, 8'h02, "badkick_err");
    wr(2'd2, 8'h02);
    rd(2'd2, 8'h00, "keyerr_w1c");
    wr(2'd1, 8'h33);
    rd(2'd2, 8'h02, "idle_badkey");
    wr(2'd2, 8'h02);
    rd(2'd2, 8'h00, "keyerr_w1c2");

    // fire
    chk(3, 0, "cr_pre");
    pc_rst = 1'b1;
    idle(3);
    chk(1, 32'b110100, "fire_not_yet");
    chk(1, 32'b110111, "fire_outs");
    pc_rst = 1'b0;
    idle(20);
    chk(3, 16, "stretch_len");
    chk(2, 1, "fire_pulse");
    rd(2'd2, 8'h01, "fired_sticky");
    wr(2'd2, 8'h01);
    rd(2'd2, 8'h00, "fired_w1c");

    // fire coinciding with KEY2
    wr(2'd1, 8'h55);
    pc_rst = 1'b1;
    idle(3);
    wr(2'd1, 8'hAA);
    chk(1, 32'b110111, "prio_outs");
    pc_rst = 1'b0;
    idle(2);
    chk(2, 1, "prio_one_pulse");
    rd(2'd2, 8'h05, "prio_status");
    idle(20);
    chk(3, 16, "prio_stretch");
    wr(2'd2, 8'h03);
    rd(2'd2, 8'h00, "prio_clr");

    // re-fire 5 cycles into stretch
    pc_rst = 1'b1;
    idle(2);
    pc_rst = 1'b0;
    idle(3);
    pc_rst = 1'b1;
    idle(2);
    pc_rst = 1'b0;
    idle(30);
    chk(3, 21, "refire_len");
    chk(2, 2, "refire_pulses");
    rd(2'd2, 8'h01, "refire_status");

    // reset mid-stretch
    pc_rst = 1'b1;
    idle(1);
    pc_rst = 1'b0;
    idle(5);
    chk(1, 32'b110101, "mid_stretch");
    rst = 1'b1;
    idle(1);
    chk(1, 32'b000010, "rst_mid_stretch");
    rst = 1'b0;
    chk(4, 0, "clr2");
    rd(2'd0, 8'h00, "ctrl_after_rst");
    rd(2'd2, 8'h00, "status_after_rst");

`ifdef WDT_CTRL_LOCK_EN
    wr(2'd0, 8'h81);
    wr(2'd0, 8'h00);
    chk(1, 32'b100000, "lock_ignored");
    idle(1);
    chk(2, 1, "lock_one_pulse");
    rd(2'd0, 8'h81, "lock_readback");
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk(4, 0, "clr3");
    wr(2'd0, 8'h01);
    rd(2'd0, 8'h01, "unlock_by_rst");
`else
    wr(2'd0, 8'h81);
    rd(2'd0, 8'h01, "nolock_bit7");
    wr(2'd0, 8'h00);
    chk(1, 32'b000010, "nolock_writable");
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watchdog_ctrl.md
# watchdog_ctrl

Register-mapped controller that configures and services the `watchdog` timer block. It provides a byte-wide write/read port from the CPU bus and drives the watchdog's `EN` and `prescale_0..2` inputs. Servicing uses a two-byte key sequence. The controller turns the watchdog's `pc_rst` into a stretched, single-source `cpu_rst` and keeps sticky cause flags that software can read after the reset.

## Interface
Parameters:
- `RST_STRETCH`, 16: number of `clk` cycles `cpu_rst` is held per watchdog fire (range 1..255).
- `KEY1`, 8'h55: first kick key.
- `KEY2`, 8'hAA: second kick key.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe, sampled on the `clk` rising edge.
- `addr` in 2: register select (0 CTRL, 1 KICK, 2 STATUS, 3 ID).
- `wdata` in 8: write data.
- `rdata` out 8: combinational read of the register selected by `addr`.
- `pc_rst` in 1: fire level from `watchdog`; asynchronous to `clk`.
- `EN` out 1: watchdog enable.
- `prescale_0` out 1: prescale bit 0.
- `prescale_1` out 1: prescale bit 1.
- `prescale_2` out 1: prescale bit 2.
- `watchdog_rst` out 1: registered clear pulse to `watchdog`.
- `cpu_rst` out 1: stretched reset to the PC/core.

## Operation
- **CTRL (addr 0):** bit0 = EN, bits3:1 = prescale[2:0], bit7 = LOCK (see Configuration). Bits 6:4 read 0.
- **CTRL write:** an accepted write updates the register and pulses `watchdog_rst` for 1 cycle. This restarts the counter under the new divider.
- **KICK (addr 1):** write-only; reads 8'h00. Two-state FSM:
  - K_IDLE + write `KEY1` → K_ARMED.
  - K_IDLE + any other value → set KEY_ERR, stay in K_IDLE.
  - K_ARMED + write `KEY2` → 1-cycle `watchdog_rst` pulse, → K_IDLE.
  - K_ARMED + any other value → set KEY_ERR, → K_IDLE.
  - Writes to other addresses do not change the FSM state.
- **STATUS (addr 2):**
  - bit0 = WDT_FIRED, sticky; bit1 = KEY_ERR, sticky; bit2 = `cpu_rst` live; bit3 = FSM state (1 = K_ARMED).
  - Write-1-to-clear on bits 1:0. Other bits are read-only.
- **ID (addr 3):** reads 8'hA5; writes are ignored.
- **Fire path:**
  - `pc_rst` passes through a 2-flop synchronizer, then rising-edge detection.
  - On an edge: set WDT_FIRED, load the stretch counter with `RST_STRETCH`, pulse `watchdog_rst` for 1 cycle (clears `pc_rst` in `watchdog`), and force the FSM to K_IDLE.
  - `cpu_rst` = (stretch counter != 0). The counter decrements each cycle to 0.
- `cpu_rst` does not reset this block; only `rst` does. Configuration and flags therefore survive a watchdog-induced reset.

## Timing
- **Reset values:** `EN`=0, `prescale_*`=0, LOCK=0, flags=0, FSM=K_IDLE, stretch counter=0, `cpu_rst`=0.
  - `watchdog_rst`=1 while `rst` is high; it is first 0 in the cycle after `rst` deasserts.
  - `rdata` follows `addr` from the reset register values.
- **Register writes:** take effect at the write edge; `EN`/`prescale_*` change at that edge. The `watchdog_rst` pulse is high for the cycle following the write edge.
- **Kick latency:** `KEY2` write at edge N → `watchdog_rst` high for cycle N+1 only.
- **Fire latency:** `pc_rst` rises before edge N → edge detected at N+2 → `cpu_rst`, WDT_FIRED and `watchdog_rst` high from N+3. `cpu_rst` stays high exactly `RST_STRETCH` cycles.
- **Re-fire during stretch:** the counter reloads to `RST_STRETCH` (extends the reset, no stacking).
- **Kick completion and fire in the same cycle:** the fire takes priority. A single `watchdog_rst` pulse is issued and the FSM goes to K_IDLE.
- **Flag set and write-1-clear of that flag in the same cycle:** the set wins.
- **Simultaneous `watchdog_rst` causes** (CTRL write, kick, fire): merged into one 1-cycle pulse.
- **`rst` mid-stretch:** `cpu_rst` drops in the cycle after the reset edge and all state returns to reset values.

## Configuration
- **`WDT_CTRL_LOCK_EN` defined:**
  - Writing CTRL with bit7=1 sets LOCK. LOCK clears only on `rst`.
  - While LOCK=1, CTRL writes are ignored entirely: no register update and no `watchdog_rst` pulse.
  - KICK and STATUS are unaffected.
- **Not defined:** bit7 reads 0, the LOCK flop is absent, and CTRL is always writable.

## Test plan
- **Reset:** hold `rst` 3 cycles → `watchdog_rst`=1 throughout, all other outputs 0. ID read = 8'hA5; STATUS = 8'h00.
- **CTRL write:** write CTRL=8'h0B → `EN`=1 and prescale=3'b101 at the write edge. `watchdog_rst` is high exactly 1 cycle. Readback = 8'h0B.
- **Kick sequences:**
  - KICK 8'h55 then 8'hAA → one `watchdog_rst` pulse; STATUS bit1=0.
  - KICK 8'h55 then 8'h12 → no pulse; STATUS = 8'h02. Writing STATUS 8'h02 clears it to 0.
- **Fire:** raise `pc_rst` → `cpu_rst` high 3 cycles later, for exactly 16 cycles. One `watchdog_rst` pulse; STATUS bit0=1 persists after `cpu_rst` falls.
- **Fire priority and re-fire:**
  - `pc_rst` edge coincides with the `KEY2` write → fire behaviour only, FSM K_IDLE.
  - A second fire 5 cycles into the stretch → `cpu_rst` total 21 cycles.
- **With `WDT_CTRL_LOCK_EN`:** write CTRL=8'h81, then CTRL=8'h00 → `EN` stays 1 with no pulse on the second write. `rst` clears LOCK.
